// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM state type for the program loader, the processor
// and the writable program memory.
package prog_loader_pkg;

    localparam int unsigned WORD_W_DEF = 9;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StWrite,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/bit_deser.sv
// MSB-first serial-to-parallel shifter with a wrapping bit counter; used for
// both data words and the trailing checksum word.
module bit_deser #(
    parameter int unsigned WORD_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              ser_bit,
    output logic              last,
    output logic [WORD_W-1:0] word_next
);

    localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // last only says the next accepted bit completes a word; caller gates it
    assign last      = (cnt_q == CNT_W'(WORD_W - 1));
    assign word_next = (word_q << 1) | WORD_W'(ser_bit);

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = word_next;
            cnt_d  = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: deserializes len+1 words into the program memory
// write port, then verifies an XOR checksum word while holding the CPU.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic              ser_valid,
    input  logic              ser_bit,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [WORD_W-1:0] chk_q, chk_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;

    logic              deser_clr;
    logic              deser_shift;
    logic              deser_last;
    logic [WORD_W-1:0] deser_word_next;

    bit_deser #(
        .WORD_W (WORD_W)
    ) u_bit_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (deser_clr),
        .shift_en  (deser_shift),
        .ser_bit   (ser_bit),
        .last      (deser_last),
        .word_next (deser_word_next)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        chk_d       = chk_q;
        err_d       = err_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        deser_clr   = 1'b0;
        deser_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d     = len;
                    addr_d    = '0;
                    chk_d     = '0;
                    err_d     = 1'b0;
                    deser_clr = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (ser_valid) begin
                    deser_shift = 1'b1;
                    // Write port is loaded here so it is registered during StWrite
                    if (deser_last) begin
                        state_d   = StWrite;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = deser_word_next;
                    end
                end
            end
            StWrite: begin
                chk_d = chk_q ^ wr_data_q;
                if (ser_valid) begin
                    err_d = 1'b1;
                end
                if (addr_q == len_q) begin
                    state_d = StCheck;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StShift;
                end
            end
            StCheck: begin
                if (ser_valid) begin
                    deser_shift = 1'b1;
                    if (deser_last) begin
                        if (deser_word_next == chk_q) begin
                            state_d = StDone;
                        end else begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides every transition above, including a pending write
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            err_d       = 1'b1;
            wr_en_d     = 1'b0;
            wr_addr_d   = wr_addr_q;
            wr_data_d   = wr_data_q;
            deser_shift = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            len_q     <= '0;
            chk_q     <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != StIdle);
    assign cpu_hold = busy;
    assign done     = (state_q == StDone);
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed load scenarios plus random stimulus, checked
// every cycle against a behavioural session model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       abort;
    logic       ser_valid;
    logic       ser_bit;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic       cpu_hold;
    logic       done;
    logic       err;

    prog_loader #(
        .WORD_W (9),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural session model
    localparam int MIdle = 0, MShift = 1, MWrite = 2, MCheck = 3, MDone = 4;
    int         m_mode;
    int         m_bits;
    logic [3:0] m_len, m_addr, m_waddr;
    logic [8:0] m_word, m_chk, m_wdata;
    logic       m_err;

    task automatic model_reset();
        m_mode  = MIdle;
        m_bits  = 0;
        m_len   = '0;
        m_addr  = '0;
        m_waddr = '0;
        m_word  = '0;
        m_chk   = '0;
        m_wdata = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_mode == MIdle) begin
            if (start) begin
                m_len  = len;
                m_addr = '0;
                m_chk  = '0;
                m_err  = 1'b0;
                m_bits = 0;
                m_word = '0;
                m_mode = MShift;
            end
        end else if (abort) begin
            m_mode = MIdle;
            m_err  = 1'b1;
        end else begin
            case (m_mode)
                MShift: if (ser_valid) begin
                    m_word = {m_word[7:0], ser_bit};
                    m_bits++;
                    if (m_bits == 9) begin
                        m_bits  = 0;
                        m_waddr = m_addr;
                        m_wdata = m_word;
                        m_mode  = MWrite;
                    end
                end
                MWrite: begin
                    m_chk = m_chk ^ m_wdata;
                    if (ser_valid) m_err = 1'b1;
                    if (m_addr == m_len) m_mode = MCheck;
                    else begin
                        m_addr = m_addr + 4'd1;
                        m_mode = MShift;
                    end
                end
                MCheck: if (ser_valid) begin
                    m_word = {m_word[7:0], ser_bit};
                    m_bits++;
                    if (m_bits == 9) begin
                        m_bits = 0;
                        if (m_word == m_chk) m_mode = MDone;
                        else begin
                            m_mode = MIdle;
                            m_err  = 1'b1;
                        end
                    end
                end
                default: m_mode = MIdle;
            endcase
        end
    endtask

    // DUT-side write/done log for the directed literal checks
    logic [3:0] log_addr[$];
    logic [8:0] log_data[$];
    int         done_cnt;
    logic       cmp_en = 1'b1;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("wr_en", 32'(wr_en), 32'(m_mode == MWrite));
            check("busy", 32'(busy), 32'(m_mode != MIdle));
            check("cpu_hold", 32'(cpu_hold), 32'(m_mode != MIdle));
            check("done", 32'(done), 32'(m_mode == MDone));
            check("err", 32'(err), 32'(m_err));
            if (m_mode == MWrite || !rst_n) begin
                check("wr_addr", 32'(wr_addr), rst_n ? 32'(m_waddr) : 32'd0);
                check("wr_data", 32'(wr_data), rst_n ? 32'(m_wdata) : 32'd0);
            end
        end
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic drive_bit(input logic b);
        if ($urandom_range(0, 3) == 0) begin
            ser_valid = 1'b0;
            tick();
        end
        ser_valid = 1'b1;
        ser_bit   = b;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic drive_word(input logic [8:0] w, input int nbits);
        for (int i = 8; i > 8 - nbits; i--) drive_bit(w[i]);
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    logic [8:0] buf_w[16];

    task automatic run_load(input logic [3:0] l, input logic [8:0] chkw);
        do_start(l);
        for (int k = 0; k <= int'(l); k++) begin
            drive_word(buf_w[k], 9);
            tick();
        end
        drive_word(chkw, 9);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        ser_valid = 1'b0; ser_bit = 1'b0;
        model_reset();
        clear_log();
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Two-word load with matching checksum
        clear_log();
        buf_w[0] = 9'b101010101;
        buf_w[1] = 9'b000011111;
        run_load(4'd1, 9'b101001010);
        check("s1 writes", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("s1 addr0", 32'(log_addr[0]), 32'd0);
            check("s1 data0", 32'(log_data[0]), 32'h155);
            check("s1 addr1", 32'(log_addr[1]), 32'd1);
            check("s1 data1", 32'(log_data[1]), 32'h01f);
        end
        check("s1 done", 32'(done_cnt), 32'd1);
        check("s1 err", 32'(err), 32'd0);

        // Same load, wrong checksum
        clear_log();
        run_load(4'd1, 9'b000000000);
        check("s2 writes", 32'(log_addr.size()), 32'd2);
        check("s2 done", 32'(done_cnt), 32'd0);
        check("s2 err", 32'(err), 32'd1);
        check("s2 busy", 32'(busy), 32'd0);

        // Full 16-word load, XOR of 0..15 is 0
        clear_log();
        for (int k = 0; k < 16; k++) buf_w[k] = 9'(k);
        run_load(4'd15, 9'h000);
        tick();
        check("s3 writes", 32'(log_addr.size()), 32'd16);
        for (int k = 0; k < 16 && k < log_addr.size(); k++) begin
            check("s3 addr", 32'(log_addr[k]), 32'(k));
            check("s3 data", 32'(log_data[k]), 32'(k));
        end
        check("s3 done", 32'(done_cnt), 32'd1);

        // Abort four bits into word 2
        clear_log();
        buf_w[0] = 9'h1a3; buf_w[1] = 9'h04c; buf_w[2] = 9'h0f0;
        do_start(4'd3);
        drive_word(buf_w[0], 9); tick();
        drive_word(buf_w[1], 9); tick();
        drive_word(buf_w[2], 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("s4 busy", 32'(busy), 32'd0);
        check("s4 err", 32'(err), 32'd1);
        tick();
        check("s4 writes", 32'(log_addr.size()), 32'd2);
        do_start(4'd0);
        check("s4 err cleared", 32'(err), 32'd0);
        check("s4 busy again", 32'(busy), 32'd1);
        drive_word(9'h0aa, 9); tick();
        drive_word(9'h0aa, 9); tick();
        check("s4 done", 32'(done_cnt), 32'd1);

        // Reset pulse in the middle of word 1
        clear_log();
        do_start(4'd2);
        drive_word(9'h111, 9); tick();
        drive_word(9'h0ff, 3);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("s5 wr_en", 32'(wr_en), 32'd0);
        check("s5 busy", 32'(busy), 32'd0);
        check("s5 wr_addr", 32'(wr_addr), 32'd0);
        check("s5 wr_data", 32'(wr_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("s5 writes", 32'(log_addr.size()), 32'd1);
        clear_log();
        buf_w[0] = 9'h07e;
        run_load(4'd0, 9'h07e);
        check("s5 reload writes", 32'(log_addr.size()), 32'd1);
        check("s5 reload done", 32'(done_cnt), 32'd1);

        // Overrun bit during WRITE, plus a start while busy
        clear_log();
        buf_w[0] = 9'h123; buf_w[1] = 9'h0c5;
        do_start(4'd1);
        drive_word(buf_w[0], 9);
        ser_valid = 1'b1; ser_bit = 1'b1; start = 1'b1; len = 4'd7;
        tick();
        ser_valid = 1'b0; start = 1'b0;
        check("s6 err", 32'(err), 32'd1);
        check("s6 busy", 32'(busy), 32'd1);
        drive_word(buf_w[1], 9); tick();
        drive_word(9'h123 ^ 9'h0c5, 9);
        tick();
        check("s6 writes", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) check("s6 data1", 32'(log_data[1]), 32'h0c5);
        check("s6 done", 32'(done_cnt), 32'd1);
        check("s6 err sticky", 32'(err), 32'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 19) == 0);
            len       = 4'($urandom_range(0, 15));
            abort     = ($urandom_range(0, 149) == 0);
            ser_valid = ($urandom_range(0, 9) < 7);
            ser_bit   = 1'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; ser_valid = 1'b0;
        tick();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 9, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, program-memory address width (16 words).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have the following ports:
- start  input  1  begin a load session.
- len  input  ADDR_W  index of the last word to load (word count minus 1); sampled at start.
- abort  input  1  cancel the session.
- ser_valid  input  1  ser_bit is valid this cycle.
- ser_bit  input  1  serial data bit, MSB first.
- wr_en  output  1  program-memory write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  WORD_W  write data.
- busy  output  1  session in progress.
- cpu_hold  output  1  holds processor PC/fetch while loading.
- done  output  1  one-cycle pulse on successful load.
- err  output  1  sticky error flag.

Function
REQ-005 SHALL implement FSM states IDLE, SHIFT, WRITE, CHECK, DONE.
REQ-006 In IDLE, start=1 SHALL latch len, clear addr, bit count, checksum and err, and go to SHIFT next cycle.
REQ-007 start outside IDLE SHALL be ignored.
REQ-008 In SHIFT, each cycle with ser_valid=1 SHALL shift ser_bit into the LSB of the word register and increment the bit count.
- Cycles with ser_valid=0 SHALL hold all state (no timeout).
REQ-009 Acceptance of the WORD_W-th bit SHALL move the FSM to WRITE; the bit count SHALL wrap to 0.
REQ-010 WRITE SHALL last exactly one cycle with wr_en=1, wr_addr=addr and wr_data=the assembled word.
- The checksum SHALL be updated as checksum XOR word in the same cycle.
REQ-011 From WRITE: if addr==len, go to CHECK; otherwise increment addr and return to SHIFT.
REQ-012 ser_valid=1 during WRITE SHALL NOT be shifted in and SHALL set err (overrun); the session continues.
REQ-013 CHECK SHALL deserialize one further WORD_W-bit word as in REQ-008, with wr_en held at 0.
- On its last bit, go to DONE if the word equals the checksum.
- Otherwise go to IDLE with err=1.
REQ-014 DONE SHALL last one cycle with done=1; it SHALL then go to IDLE.
- err from REQ-012 SHALL remain visible.
REQ-015 abort=1 in any non-IDLE state SHALL return the FSM to IDLE next cycle and set err=1.
- wr_en SHALL be 0 in that cycle and all later cycles until the next start.
- abort SHALL take priority over every other transition in the same cycle.
REQ-016 busy SHALL be 1 in SHIFT, WRITE, CHECK and DONE, and 0 in IDLE.
- cpu_hold SHALL equal busy.
REQ-017 wr_en SHALL be 1 only in WRITE.
- wr_addr and wr_data SHALL be registered outputs.
- wr_addr SHALL never exceed the latched len.
REQ-018 len=0 SHALL load exactly one word before CHECK.
- len=15 SHALL load 16 words; addr SHALL NOT wrap past 15.
REQ-019 err SHALL be cleared only by reset or by an accepted start.

Reset
REQ-020 rst_n=0 SHALL immediately force the following, regardless of FSM state:
- state=IDLE.
- wr_en=0, wr_addr=0, wr_data=0.
- busy=0, cpu_hold=0, done=0, err=0.
- Bit count, addr, checksum and latched len cleared to 0.
REQ-021 Reset asserted mid-session SHALL discard the partial word, with no write.
- Release SHALL resume in IDLE on the first clk edge after rst_n=1.

Structure
REQ-022 A shared package prog_loader_pkg SHALL hold the FSM state enum and the WORD_W/ADDR_W defaults.
- The processor and the writable program memory SHALL import the same constants.
REQ-023 The serial-to-parallel shifter with bit counter SHALL be a sub-module bit_deser, reused for data words and the checksum word.
REQ-024 The block SHALL contain no memory.
- It drives the write port of the processor's writable program memory.
- It holds the fetch stage through cpu_hold.

Verification
REQ-025 Bench SHALL cover the following scenarios:
- len=1, words 9'b101010101 and 9'b000011111, checksum 9'b101001010 -> wr_en pulses at addr 0 and 1 with those data; done pulse; err=0.
- Same load with checksum 9'b000000000 -> two writes; no done; err=1; busy=0.
- len=15, words 0..15, checksum 9'h000 -> 16 writes at addresses 0..15 in order; done=1; wr_addr never wraps.
- abort after 4 bits of word 2 (len=3) -> exactly two writes; err=1; IDLE next cycle; start then clears err.
- rst_n low for one cycle mid-word 1 -> all outputs 0; no further writes; next start loads cleanly.
- ser_valid=1 in the WRITE cycle -> that bit is dropped; err=1; start asserted while busy is ignored.
